// File: rtl/mine_counter_if.sv
// mine_counter_if: controller/board bus of the mine counting scan engine
interface mine_counter_if #(
  parameter int x_coord_bits = 4,
  parameter int y_coord_bits = 4
);
  logic                                start;
  logic                                board_ready;
  logic [x_coord_bits-1:0]             rd_x;
  logic [y_coord_bits-1:0]             rd_y;
  logic [4:0]                          rd_val;
  logic                                wr_en;
  logic [x_coord_bits-1:0]             wr_x;
  logic [y_coord_bits-1:0]             wr_y;
  logic [4:0]                          wr_val;
  logic                                busy;
  logic                                done;
  logic [x_coord_bits+y_coord_bits:0]  safe_cells;
  modport slave (
    input  start, board_ready, rd_val,
    output rd_x, rd_y, wr_en, wr_x, wr_y, wr_val, busy, done, safe_cells
  );
  modport master (
    output start, board_ready, rd_val,
    input  rd_x, rd_y, wr_en, wr_x, wr_y, wr_val, busy, done, safe_cells
  );
endinterface

// File: rtl/mine_counter.sv
// mine_counter: scans the board and writes the neighbour mine count of every safe cell
module mine_counter #(
  parameter int         x_size       = 16,
  parameter int         y_size       = 16,
  parameter int         x_coord_bits = 4,
  parameter int         y_coord_bits = 4,
  parameter logic [4:0] mine_code    = 5'h1F
) (
  input logic           clk,
  input logic           reset,
  mine_counter_if.slave bus
);
  localparam int XB = x_coord_bits;
  localparam int YB = y_coord_bits;
  localparam int SB = XB + YB + 1;
  localparam logic [XB:0]   XLIM  = (XB+1)'(x_size);
  localparam logic [YB:0]   YLIM  = (YB+1)'(y_size);
  localparam logic [XB-1:0] XLAST = XB'(x_size - 1);
  localparam logic [YB-1:0] YLAST = YB'(y_size - 1);
  // 2-bit signed offsets per slot, slot 0 (centre) in the low bits: 11=-1, 00=0, 01=+1
  localparam logic [17:0] DX = 18'b01_00_11_01_11_01_00_11_00;
  localparam logic [17:0] DY = 18'b01_01_01_00_00_11_11_11_00;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cyc_q, cyc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [XB-1:0] cx_q, cx_d, rd_x_q, rd_x_d, wr_x_q, wr_x_d;
  logic [YB-1:0] cy_q, cy_d, rd_y_q, rd_y_d, wr_y_q, wr_y_d;
  logic          is_mine_q, is_mine_d;
  logic          wr_en_q, wr_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [4:0]    wr_val_q, wr_val_d;
  logic [SB-1:0] safe_q, safe_d;
  logic          accept, cell_end, last_cell, hit, wr_cyc;

  // Neighbour coordinates carry one extra bit so that -1 and size land out of range
  function automatic logic [XB:0] nbr_x(input int s, input logic [XB-1:0] x);
    logic [1:0] d;
    d = (s >= 1 && s <= 8) ? DX[2*s +: 2] : 2'b00;
    return {1'b0, x} + {{(XB-1){d[1]}}, d};
  endfunction

  function automatic logic [YB:0] nbr_y(input int s, input logic [YB-1:0] y);
    logic [1:0] d;
    d = (s >= 1 && s <= 8) ? DY[2*s +: 2] : 2'b00;
    return {1'b0, y} + {{(YB-1){d[1]}}, d};
  endfunction

  function automatic logic in_bounds(input int s, input logic [XB-1:0] x, input logic [YB-1:0] y);
    return nbr_x(s, x) < XLIM && nbr_y(s, y) < YLIM;
  endfunction

  // Next-state decode: 11-cycle cell schedule, row-major cell walk, registered outputs
  always_comb begin
    accept    = state_q == IDLE && bus.start && bus.board_ready;
    cell_end  = state_q == SCAN && cyc_q == 4'd10;
    last_cell = cx_q == XLAST && cy_q == YLAST;
    wr_cyc    = state_q == SCAN && cyc_q == 4'd9;
    hit       = state_q == SCAN && cyc_q >= 4'd2 && cyc_q <= 4'd9 && bus.rd_val == mine_code &&
                in_bounds(int'(cyc_q) - 1, cx_q, cy_q);
    state_d   = accept ? SCAN : (cell_end && last_cell) ? IDLE : state_q;
    cyc_d     = (accept || cell_end) ? '0 : state_q == SCAN ? cyc_q + 4'd1 : cyc_q;
    cx_d      = accept ? '0 : cell_end ? (cx_q == XLAST ? '0 : cx_q + 1'b1) : cx_q;
    cy_d      = accept ? '0 : (cell_end && cx_q == XLAST) ? (cy_q == YLAST ? '0 : cy_q + 1'b1) : cy_q;
    is_mine_d = (state_q == SCAN && cyc_q == 4'd1) ? bus.rd_val == mine_code : is_mine_q;
    cnt_d     = cyc_q == 4'd1 ? '0 : cnt_q + 4'(hit);
    wr_en_d   = wr_cyc && !is_mine_q;
    wr_x_d    = wr_cyc ? cx_q : wr_x_q;
    wr_y_d    = wr_cyc ? cy_q : wr_y_q;
    wr_val_d  = wr_cyc ? {1'b0, cnt_d} : wr_val_q;
    busy_d    = state_d == SCAN;
    done_d    = cell_end && last_cell;
    safe_d    = accept ? '0 : safe_q + SB'(wr_en_q);
    rd_x_d    = in_bounds(int'(cyc_d), cx_d, cy_d) ? XB'(nbr_x(int'(cyc_d), cx_d)) : cx_d;
    rd_y_d    = in_bounds(int'(cyc_d), cx_d, cy_d) ? YB'(nbr_y(int'(cyc_d), cy_d)) : cy_d;
  end

  // State and output registers; reset abandons any scan in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      cnt_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      is_mine_q <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_val_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      safe_q    <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      cnt_q     <= cnt_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      is_mine_q <= is_mine_d;
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      wr_en_q   <= wr_en_d;
      wr_x_q    <= wr_x_d;
      wr_y_q    <= wr_y_d;
      wr_val_q  <= wr_val_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      safe_q    <= safe_d;
    end
  end

  assign bus.rd_x       = rd_x_q;
  assign bus.rd_y       = rd_y_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_x       = wr_x_q;
  assign bus.wr_y       = wr_y_q;
  assign bus.wr_val     = wr_val_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.safe_cells = safe_q;
endmodule
